mem_ctrl_param: RTL and testbench

- Parametrised successor to the 16x16 single-port data memory controller.
- Adds configurable width, depth and read latency, byte-lane write masking, a req/ready handshake, out-of-range error reporting, and a hardware clear sequencer that zero-fills the array.
- Sits between the datapath load/store stage and the on-chip data array.
- Accepts at most one access per cycle.

---
 rtl/mem_ctrl_param.sv | 145 ++++++++++++++
 tb/tb_mem_ctrl_param.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_param.sv
// Single-port data memory controller: byte-lane writes, range check, RD_LAT-cycle pipelined reads, zero-fill sequencer.
// ready is low while the array is being cleared; reqs seen with ready=0 are dropped, so callers must hold req until it is accepted.
module mem_ctrl_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                rwbar,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic                clr,
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                err,
    output logic                busy
);
    localparam int NB = DATA_W / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [IW-1:0]     clr_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [IW-1:0]     idx;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_word;

    // Full-width compare so aliased upper addresses are rejected, not wrapped.
    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign idx      = addr[IW-1:0];
    assign acc      = req & ready;
    assign wr_acc   = acc & ~rwbar;
    assign rd_acc   = acc & rwbar;
    assign rd_word  = in_range ? mem[idx] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    if (clr_idx == IW'(DEPTH - 1)) begin
                        state   <= ST_RUN;
                        clr_idx <= '0;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + IW'(1);
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_idx <= '0;
                    ready   <= 1'b0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; the clear sequence is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_acc && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: stage i holds a result i cycles after its accept edge.
    logic              cv [1:RD_LAT];
    logic              ce [1:RD_LAT];
    logic [DATA_W-1:0] cd [1:RD_LAT];
    logic              pv [1:RD_LAT];
    logic              pe [1:RD_LAT];
    logic [DATA_W-1:0] pd [1:RD_LAT];

    for (genvar i = 1; i <= RD_LAT; i++) begin : g_stage
        if (i == 1) begin : g_head
            assign cv[i] = rd_acc;
            assign ce[i] = ~in_range;
            assign cd[i] = rd_word;
        end else begin : g_next
            assign cv[i] = pv[i-1];
            assign ce[i] = pe[i-1];
            assign cd[i] = pd[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pe[i] <= 1'b0;
                pd[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int i = 1; i <= RD_LAT; i++) begin
                pv[i] <= cv[i];
                pe[i] <= cv[i] & ce[i];
                if (cv[i]) begin
                    pd[i] <= cd[i];
                end
            end
            // Write errors report one cycle after accept, read errors with their rvalid.
            err <= (wr_acc & ~in_range) | (cv[RD_LAT] & ce[RD_LAT]);
        end
    end

    // The last data stage only loads on a valid result, so rdata holds between pulses.
    assign rvalid = pv[RD_LAT];
    assign rdata  = pd[RD_LAT];

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Bench for mem_ctrl_param: three instances (RD_LAT 1, 2, 3) share one stimulus stream and are checked
// each cycle against a cycle-indexed behavioural model, with literal expectations on the directed scenarios.
module tb_mem_ctrl_param;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int DEP = 16;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          req   = 1'b0;
    logic          rwbar = 1'b0;
    logic          clr   = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic [1:0]    wmask = '0;

    logic          ready_w  [3];
    logic          rvalid_w [3];
    logic          err_w    [3];
    logic          busy_w   [3];
    logic [DW-1:0] rdata_w  [3];

    always #5 clk = ~clk;

    mem_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(1)) dut_l1 (
        .clk(clk), .reset(rst), .req(req), .rwbar(rwbar), .addr(addr), .wdata(wdata),
        .wmask(wmask), .clr(clr), .ready(ready_w[0]), .rdata(rdata_w[0]),
        .rvalid(rvalid_w[0]), .err(err_w[0]), .busy(busy_w[0]));
    mem_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(2)) dut_l2 (
        .clk(clk), .reset(rst), .req(req), .rwbar(rwbar), .addr(addr), .wdata(wdata),
        .wmask(wmask), .clr(clr), .ready(ready_w[1]), .rdata(rdata_w[1]),
        .rvalid(rvalid_w[1]), .err(err_w[1]), .busy(busy_w[1]));
    mem_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(3)) dut_l3 (
        .clk(clk), .reset(rst), .req(req), .rwbar(rwbar), .addr(addr), .wdata(wdata),
        .wmask(wmask), .clr(clr), .ready(ready_w[2]), .rdata(rdata_w[2]),
        .rvalid(rvalid_w[2]), .err(err_w[2]), .busy(busy_w[2]));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Results are booked into a ring indexed by the edge number on which they must appear.
    logic [DW-1:0] m_mem [DEP];
    logic          m_run = 1'b0;
    int            m_cidx = 0;
    int            e_cnt = 0;
    logic          due_v [3][8];
    logic          due_e [3][8];
    logic [DW-1:0] due_d [3][8];
    logic          m_rv  [3] = '{1'b0, 1'b0, 1'b0};
    logic          m_err [3] = '{1'b0, 1'b0, 1'b0};
    logic [DW-1:0] m_rd  [3] = '{16'h0, 16'h0, 16'h0};
    logic          m_acc, m_werr, m_inr;
    logic [DW-1:0] m_word;

    always @(posedge clk) begin
        e_cnt = e_cnt + 1;
        if (rst) begin
            m_run  = 1'b0;
            m_cidx = 0;
            for (int d = 0; d < 3; d++) begin
                m_rv[d]  = 1'b0;
                m_err[d] = 1'b0;
                m_rd[d]  = '0;
                for (int s = 0; s < 8; s++) due_v[d][s] = 1'b0;
            end
        end else begin
            m_acc  = req && m_run;
            m_inr  = (addr < DEP);
            m_werr = 1'b0;
            m_word = m_inr ? m_mem[addr[3:0]] : '0;
            if (m_acc && !rwbar) begin
                if (m_inr) begin
                    for (int b = 0; b < 2; b++)
                        if (wmask[b]) m_mem[addr[3:0]][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    m_werr = 1'b1;
                end
            end
            if (m_acc && rwbar) begin
                for (int d = 0; d < 3; d++) begin
                    due_v[d][(e_cnt + d) % 8] = 1'b1;
                    due_d[d][(e_cnt + d) % 8] = m_word;
                    due_e[d][(e_cnt + d) % 8] = !m_inr;
                end
            end
            if (!m_run) begin
                m_mem[m_cidx] = '0;
                m_cidx = m_cidx + 1;
                if (m_cidx == DEP) begin
                    m_run  = 1'b1;
                    m_cidx = 0;
                end
            end else if (clr) begin
                m_run  = 1'b0;
                m_cidx = 0;
            end
            for (int d = 0; d < 3; d++) begin
                if (due_v[d][e_cnt % 8]) begin
                    m_rv[d]  = 1'b1;
                    m_rd[d]  = due_d[d][e_cnt % 8];
                    m_err[d] = due_e[d][e_cnt % 8] | m_werr;
                    due_v[d][e_cnt % 8] = 1'b0;
                end else begin
                    m_rv[d]  = 1'b0;
                    m_err[d] = m_werr;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("ready_L%0d", d + 1),  ready_w[d],  m_run);
            chk($sformatf("busy_L%0d", d + 1),   busy_w[d],   !m_run);
            chk($sformatf("rvalid_L%0d", d + 1), rvalid_w[d], m_rv[d]);
            chk($sformatf("rdata_L%0d", d + 1),  rdata_w[d],  m_rd[d]);
            chk($sformatf("err_L%0d", d + 1),    err_w[d],    m_err[d]);
        end
    end

    // ---------------- rvalid event log for literal checks ----------------
    typedef struct {
        int            dut;
        int            cyc;
        logic [DW-1:0] dat;
        logic          er;
    } ev_t;
    ev_t evq[$];
    ev_t mon_ev;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rvalid_w[d] === 1'b1) begin
                mon_ev.dut = d;
                mon_ev.cyc = e_cnt;
                mon_ev.dat = rdata_w[d];
                mon_ev.er  = err_w[d];
                evq.push_back(mon_ev);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] lit_d [16];
    logic          lit_e [16];
    int            acc;

    task automatic drive(input logic r, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [1:0] m, input logic c);
        @(negedge clk);
        #1;
        req = r; rwbar = rw; addr = a; wdata = wd; wmask = m; clr = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, '0, '0, 2'b00, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [1:0] m);
        drive(1'b1, 1'b0, a, wd, m, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b1, 1'b1, a, '0, 2'b00, 1'b0);
    endtask

    // n results per instance, the j-th exactly RD_LAT+j cycles after the first accept edge.
    task automatic check_reads(input int n, input int acc_edge);
        for (int d = 0; d < 3; d++) begin
            int j;
            j = 0;
            foreach (evq[k]) begin
                if (evq[k].dut == d) begin
                    if (j < n) begin
                        chk($sformatf("rd_data_L%0d_%0d", d + 1, j), evq[k].dat, lit_d[j]);
                        chk($sformatf("rd_err_L%0d_%0d", d + 1, j), evq[k].er, lit_e[j]);
                        chk($sformatf("rd_lat_L%0d_%0d", d + 1, j), evq[k].cyc - acc_edge + 1, d + 1 + j);
                    end
                    j++;
                end
            end
            chk($sformatf("rd_count_L%0d", d + 1), j, n);
        end
        evq.delete();
    endtask

    task automatic measure_clear(input int lit, input string nm);
        int  cnt  [3];
        bit  done [3];
        for (int d = 0; d < 3; d++) begin
            cnt[d]  = 0;
            done[d] = 1'b0;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (!done[d]) begin
                    if (ready_w[d] === 1'b0) cnt[d]++;
                    else done[d] = 1'b1;
                end
            end
        end
        for (int d = 0; d < 3; d++) chk($sformatf("%s_L%0d", nm, d + 1), cnt[d], lit);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ready_L%0d", d + 1),  ready_w[d],  1'b0);
            chk($sformatf("rst_busy_L%0d", d + 1),   busy_w[d],   1'b1);
            chk($sformatf("rst_rvalid_L%0d", d + 1), rvalid_w[d], 1'b0);
            chk($sformatf("rst_rdata_L%0d", d + 1),  rdata_w[d],  16'h0000);
            chk($sformatf("rst_err_L%0d", d + 1),    err_w[d],    1'b0);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        // The release cycle is the first of the sixteen clear cycles; fifteen more negedges see ready low.
        measure_clear(DEP - 1, "clear_after_reset");
        evq.delete();

        for (int a = 0; a < 16; a++) begin
            rd(AW'(a));
            if (a == 0) acc = e_cnt + 1;
            lit_d[a] = 16'h0000;
            lit_e[a] = 1'b0;
        end
        idle();
        repeat (6) @(negedge clk);
        #2;
        check_reads(16, acc);

        wr(16'd3, 16'hBEEF, 2'b11);
        wr(16'd3, 16'h1234, 2'b10);
        rd(16'd3);
        acc = e_cnt + 1;
        idle();
        repeat (6) @(negedge clk);
        #2;
        chk("model_mem3", m_mem[3], 16'h12EF);
        lit_d[0] = 16'h12EF; lit_e[0] = 1'b0;
        check_reads(1, acc);

        wr(16'd1, 16'h0001, 2'b11);
        wr(16'd2, 16'h0002, 2'b11);
        wr(16'd3, 16'h0003, 2'b11);
        rd(16'd1);
        acc = e_cnt + 1;
        rd(16'd2);
        rd(16'd3);
        idle();
        repeat (6) @(negedge clk);
        #2;
        lit_d[0] = 16'h0001; lit_d[1] = 16'h0002; lit_d[2] = 16'h0003;
        lit_e[0] = 1'b0;     lit_e[1] = 1'b0;     lit_e[2] = 1'b0;
        check_reads(3, acc);

        wr(16'h0010, 16'h5A5A, 2'b11);
        @(negedge clk);
        #1;
        req = 1'b0;
        for (int d = 0; d < 3; d++) chk($sformatf("oor_wr_err_L%0d", d + 1), err_w[d], 1'b1);
        chk("model_mem0_after_oor", m_mem[0], 16'h0000);
        wr(16'd0, 16'hFFFF, 2'b00);
        rd(16'd0);
        acc = e_cnt + 1;
        rd(16'hFFFF);
        idle();
        repeat (6) @(negedge clk);
        #2;
        lit_d[0] = 16'h0000; lit_e[0] = 1'b0;
        lit_d[1] = 16'h0000; lit_e[1] = 1'b1;
        check_reads(2, acc);

        wr(16'd5, 16'hA5A5, 2'b11);
        drive(1'b1, 1'b1, 16'd5, '0, 2'b00, 1'b1);
        acc = e_cnt + 1;
        drive(1'b0, 1'b1, '0, '0, 2'b00, 1'b1);
        idle();
        // Two of the sixteen ready-low cycles elapse before counting starts; the second clr must not restart.
        measure_clear(DEP - 2, "clear_after_clr");
        lit_d[0] = 16'hA5A5; lit_e[0] = 1'b0;
        check_reads(1, acc);
        rd(16'd5);
        acc = e_cnt + 1;
        idle();
        repeat (6) @(negedge clk);
        #2;
        lit_d[0] = 16'h0000; lit_e[0] = 1'b0;
        check_reads(1, acc);

        wr(16'd7, 16'h7777, 2'b11);
        rd(16'd7);
        @(negedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        for (int d = 0; d < 3; d++) begin
            int n_ev;
            n_ev = 0;
            foreach (evq[k]) if (evq[k].dut == d) n_ev++;
            chk($sformatf("midrst_events_L%0d", d + 1), n_ev, (d == 0) ? 1 : 0);
            chk($sformatf("midrst_rdata_L%0d", d + 1), rdata_w[d], 16'h0000);
            chk($sformatf("midrst_rvalid_L%0d", d + 1), rvalid_w[d], 1'b0);
        end
        evq.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        measure_clear(DEP - 1, "clear_after_midrst");
        evq.delete();
        rd(16'd7);
        acc = e_cnt + 1;
        idle();
        repeat (6) @(negedge clk);
        #2;
        lit_d[0] = 16'h0000; lit_e[0] = 1'b0;
        check_reads(1, acc);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
